// File: rtl/sim_mon_pkg.sv
// Shared types for the simulation run monitor: FSM states, termination codes, width helper.
// Pure declarations; no latency, no flow control.
package sim_mon_pkg;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_RESET_HOLD = 2'd1,
      S_RUN        = 2'd2,
      S_DONE       = 2'd3
   } state_t;

   localparam logic [1:0] ST_NONE    = 2'b00;
   localparam logic [1:0] ST_HALT    = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_STALL   = 2'b11;

   // Counter width able to hold 0..v-1, never narrower than one bit.
   function automatic int cnt_w(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/pc_trace_buf.sv
// Circular PC trace with saturating entry count; read data registered one cycle after rd_idx_i.
// Writes accepted every enabled cycle, oldest entry overwritten when full; no backpressure.
module pc_trace_buf #(
   parameter int PC_W        = 64,
   parameter int TRACE_DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr_i,
   input  logic                           wr_en_i,
   input  logic [PC_W-1:0]                wr_pc_i,
   input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx_i,
   output logic [$clog2(TRACE_DEPTH):0]   count_o,
   output logic [PC_W-1:0]                rd_pc_o
);

   localparam int IDX_W = $clog2(TRACE_DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [PC_W-1:0]  mem_q [TRACE_DEPTH];
   logic [IDX_W-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] rd_addr;
   logic [PC_W-1:0]  rd_pc_q;

   // Index 0 is the newest entry; power-of-two depth makes the subtraction wrap for free.
   assign rd_addr = wptr_q - IDX_W'(1) - rd_idx_i;

   always_comb begin
      wptr_d  = wptr_q;
      count_d = count_q;
      if (clr_i) begin
         wptr_d  = '0;
         count_d = '0;
      end else if (wr_en_i) begin
         wptr_d = wptr_q + IDX_W'(1);
         if (count_q != CNT_W'(TRACE_DEPTH)) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         count_q <= '0;
         rd_pc_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         count_q <= count_d;
         rd_pc_q <= mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i && !clr_i) begin
         mem_q[wptr_q] <= wr_pc_i;
      end
   end

   assign count_o = count_q;
   assign rd_pc_o = rd_pc_q;

endmodule

// File: rtl/sim_run_monitor.sv
// Run-control monitor: sequences cpu reset, counts RUN cycles, traces PC changes, ends on halt/stall/timeout.
// Termination registered on the deciding edge (done next cycle); trace read has one-cycle latency; no backpressure.
module sim_run_monitor
   import sim_mon_pkg::*;
#(
   parameter int PC_W         = 64,
   parameter int TRACE_DEPTH  = 16,
   parameter int MAX_CYCLES   = 1000,
   parameter int STALL_LIMIT  = 8,
   parameter int RESET_CYCLES = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [PC_W-1:0]                pc,
   input  logic                           halted,
   output logic                           cpu_reset,
   output logic                           done,
   output logic [1:0]                     status,
   output logic [31:0]                    cycle_count,
   output logic [$clog2(TRACE_DEPTH):0]   trace_count,
   input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
   output logic [PC_W-1:0]                trace_rd_pc
);

   localparam int HOLD_W  = cnt_w(RESET_CYCLES);
   localparam int STALL_W = $clog2(STALL_LIMIT + 1);

   state_t             state_q, state_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [31:0]        cycle_q, cycle_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic [1:0]         status_q, status_d;
   logic [PC_W-1:0]    last_pc_q, last_pc_d;
   logic               trace_clr, trace_wr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         cycle_q   <= '0;
         stall_q   <= '0;
         status_q  <= ST_NONE;
         last_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         cycle_q   <= cycle_d;
         stall_q   <= stall_d;
         status_q  <= status_d;
         last_pc_q <= last_pc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      cycle_d   = cycle_q;
      stall_d   = stall_q;
      status_d  = status_q;
      last_pc_d = last_pc_q;
      trace_clr = 1'b0;
      trace_wr  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_RESET_HOLD;
               hold_d    = '0;
               cycle_d   = '0;
               stall_d   = '0;
               status_d  = ST_NONE;
               trace_clr = 1'b1;
            end
         end
         S_RESET_HOLD: begin
            if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
               state_d = S_RUN;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         S_RUN: begin
            cycle_d = cycle_q + 32'd1;
            // cycle_q is zero only on the first RUN cycle, when last_pc holds nothing meaningful.
            if ((cycle_q == 32'd0) || (pc != last_pc_q)) begin
               trace_wr  = 1'b1;
               last_pc_d = pc;
               stall_d   = '0;
            end else if (stall_q != STALL_W'(STALL_LIMIT)) begin
               stall_d = stall_q + STALL_W'(1);
            end
            if (halted) begin
               status_d = ST_HALT;
               state_d  = S_DONE;
            end else if (stall_d == STALL_W'(STALL_LIMIT)) begin
               status_d = ST_STALL;
               state_d  = S_DONE;
            end else if (cycle_d == 32'(MAX_CYCLES)) begin
               status_d = ST_TIMEOUT;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Decoded straight from state so the async reset asserts cpu_reset without waiting for a clock.
   assign cpu_reset   = (state_q == S_IDLE) || (state_q == S_RESET_HOLD);
   assign done        = (state_q == S_DONE);
   assign status      = status_q;
   assign cycle_count = cycle_q;

   pc_trace_buf #(
      .PC_W        (PC_W),
      .TRACE_DEPTH (TRACE_DEPTH)
   ) u_trace (
      .clk      (clk),
      .rst      (reset),
      .clr_i    (trace_clr),
      .wr_en_i  (trace_wr),
      .wr_pc_i  (pc),
      .rd_idx_i (trace_rd_idx),
      .count_o  (trace_count),
      .rd_pc_o  (trace_rd_pc)
   );

endmodule
